// File: rtl/branch_sequencer.sv
// Control sequencer for one conditional branch: T3..T6 datapath strobes, a
// one-cycle done/taken report at FIN, and saturating taken/not-taken counters.
module branch_sequencer (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  cond,
  input  logic        stall,
  input  logic        abort,
  input  logic        con_ff,
  input  logic        clr_stats,
  output logic        gra,
  output logic        r_out,
  output logic        con_in,
  output logic        pc_out,
  output logic        y_in,
  output logic        c_out,
  output logic        alu_add,
  output logic        z_in,
  output logic        zlow_out,
  output logic        pc_in,
  output logic [1:0]  cond_sel,
  output logic        busy,
  output logic        done,
  output logic        taken,
  output logic [15:0] taken_cnt,
  output logic [15:0] not_taken_cnt
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StT3   = 3'd1,
    StT4   = 3'd2,
    StT5   = 3'd3,
    StT6   = 3'd4,
    StFin  = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  cond_sel_q, cond_sel_d;
  logic        taken_q, taken_d;
  logic [15:0] taken_cnt_q, taken_cnt_d;
  logic [15:0] not_taken_cnt_q, not_taken_cnt_d;
  logic        fin_fire;
  logic        act;

  // A state only does work in a cycle that is neither stalled nor aborted.
  assign act      = !stall && !abort;
  assign fin_fire = (state_q == StFin) && act;

  // Next-state, condition capture, taken latch and statistics counters.
  always_comb begin
    state_d         = state_q;
    cond_sel_d      = cond_sel_q;
    taken_d         = taken_q;
    taken_cnt_d     = taken_cnt_q;
    not_taken_cnt_d = not_taken_cnt_q;

    if (abort) begin
      // Abort beats stall and also swallows a start presented in IDLE.
      state_d = StIdle;
    end else if (!stall) begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_d    = StT3;
            cond_sel_d = cond;
          end
        end
        StT3:    state_d = StT4;
        StT4:    state_d = StT5;
        StT5:    state_d = StT6;
        StT6: begin
          state_d = StFin;
          taken_d = con_ff;
        end
        StFin:   state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end

    if (fin_fire) begin
      if (taken_q) begin
        if (taken_cnt_q != 16'hFFFF) taken_cnt_d = taken_cnt_q + 16'd1;
      end else begin
        if (not_taken_cnt_q != 16'hFFFF) not_taken_cnt_d = not_taken_cnt_q + 16'd1;
      end
    end

    // Clear wins over a coincident FIN increment.
    if (clr_stats) begin
      taken_cnt_d     = 16'd0;
      not_taken_cnt_d = 16'd0;
    end
  end

  // State and bookkeeping registers, asynchronously cleared.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= StIdle;
      cond_sel_q      <= 2'b00;
      taken_q         <= 1'b0;
      taken_cnt_q     <= 16'd0;
      not_taken_cnt_q <= 16'd0;
    end else begin
      state_q         <= state_d;
      cond_sel_q      <= cond_sel_d;
      taken_q         <= taken_d;
      taken_cnt_q     <= taken_cnt_d;
      not_taken_cnt_q <= not_taken_cnt_d;
    end
  end

  // Strobes decoded from the current state, silenced on stall/abort cycles.
  always_comb begin
    gra      = 1'b0;
    r_out    = 1'b0;
    con_in   = 1'b0;
    pc_out   = 1'b0;
    y_in     = 1'b0;
    c_out    = 1'b0;
    alu_add  = 1'b0;
    z_in     = 1'b0;
    zlow_out = 1'b0;
    pc_in    = 1'b0;
    if (act) begin
      case (state_q)
        StT3: begin
          gra    = 1'b1;
          r_out  = 1'b1;
          con_in = 1'b1;
        end
        StT4: begin
          pc_out = 1'b1;
          y_in   = 1'b1;
        end
        StT5: begin
          c_out   = 1'b1;
          alu_add = 1'b1;
          z_in    = 1'b1;
        end
        StT6: begin
          zlow_out = 1'b1;
          pc_in    = con_ff;
        end
        default: ;
      endcase
    end
  end

  assign cond_sel      = cond_sel_q;
  assign busy          = (state_q != StIdle);
  assign done          = fin_fire;
  assign taken         = taken_q;
  assign taken_cnt     = taken_cnt_q;
  assign not_taken_cnt = not_taken_cnt_q;

endmodule
